// File: rtl/calc_token_sequencer.sv
// calc_token_sequencer
//   Converts keypad events into calculator-core tokens. Decimal digits build
//   a signed-positive 31-bit operand; operator keys A-E become 0x8000000A..E
//   tokens and clear (F) becomes 0x8000000F. Tokens are queued in a small
//   FIFO and handed to the core one at a time over a strobe/ready handshake.
//   Also selects the value driven to the display.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_valid    single-cycle pulse qualifying key_code
//   key_code     0-9 digit, A + , B - , C * , D / , E = , F clear
//   calc_ready   core can accept a token
//   calc_answer  core result
//   calc_strobe  one-cycle token strobe to the core
//   calc_token   token presented to the core, held from pop to next pop
//   disp_value   pending operand while one is being typed, else calc_answer
//   busy         FIFO holds tokens or a dispatch is in progress
//   dropped      one-cycle pulse: operator key rejected, FIFO too full
//   entry_err    sticky operand-overflow flag, cleared by the clear key
//   calc_timeout one-cycle pulse: core did not return ready in time
module calc_token_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        calc_ready,
  input  logic [31:0] calc_answer,
  output logic        calc_strobe,
  output logic [31:0] calc_token,
  output logic [31:0] disp_value,
  output logic        busy,
  output logic        dropped,
  output logic        entry_err,
  output logic        calc_timeout
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [31:0]   CLEAR_TOK  = 32'h8000_000F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_HOLD,
    S_WAIT
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t          state_q,     state_d;
  logic [31:0]     acc_q,       acc_d;
  logic            pending_q,   pending_d;
  logic            entry_err_q, entry_err_d;
  logic            dropped_q,   dropped_d;
  logic            strobe_q,    strobe_d;
  logic [31:0]     token_q,     token_d;
  logic            timeout_q,   timeout_d;
  logic [TW-1:0]   timer_q,     timer_d;
  logic [31:0]     disp_q,      disp_d;
  logic            busy_q,      busy_d;
  logic [PW-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]   count_q,     count_d;

  logic [31:0]     mem_q [FIFO_DEPTH];

  // Two write ports: a pending operand and its operator land in one cycle.
  logic            wr0_en,   wr1_en;
  logic [PW-1:0]   wr0_addr, wr1_addr;
  logic [31:0]     wr0_data, wr1_data;

  logic            pop;
  logic            flush;
  logic [1:0]      push_n;
  logic [CW-1:0]   free;
  logic [34:0]     next_val;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    pending_d   = pending_q;
    entry_err_d = entry_err_q;
    dropped_d   = 1'b0;
    strobe_d    = 1'b0;
    token_d     = token_q;
    timeout_d   = 1'b0;
    timer_d     = timer_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    wr0_en   = 1'b0;
    wr0_addr = wr_ptr_q;
    wr0_data = '0;
    wr1_en   = 1'b0;
    wr1_addr = wr_ptr_q + 1'b1;
    wr1_data = '0;

    pop      = 1'b0;
    flush    = 1'b0;
    push_n   = 2'd0;
    free     = DEPTH_C - count_q;
    next_val = {3'b000, acc_q} * 35'd10 + {31'd0, key_code};

    // Dispatcher
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && calc_ready) begin
          pop      = 1'b1;
          token_d  = mem_q[rd_ptr_q];
          strobe_d = 1'b1;
          state_d  = S_STROBE;
        end
      end
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (calc_ready) begin
          state_d = S_IDLE;
        end else if (TIMEOUT != 0) begin
          if (timer_q == TIMER_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Key decoding
    if (key_valid) begin
      if (key_code <= 4'd9) begin
        if (next_val <= 35'h0_7FFF_FFFF) begin
          acc_d     = next_val[31:0];
          pending_d = 1'b1;
        end else begin
          entry_err_d = 1'b1;
        end
      end else if (key_code == 4'hF) begin
        flush       = 1'b1;
        acc_d       = '0;
        pending_d   = 1'b0;
        entry_err_d = 1'b0;
      end else if (pending_q) begin
        if (free >= CW'(2)) begin
          wr0_en    = 1'b1;
          wr0_data  = {1'b0, acc_q[30:0]};
          wr1_en    = 1'b1;
          wr1_data  = {28'h800_0000, key_code};
          push_n    = 2'd2;
          acc_d     = '0;
          pending_d = 1'b0;
        end else begin
          dropped_d = 1'b1;
        end
      end else begin
        if (free != '0) begin
          wr0_en   = 1'b1;
          wr0_data = {28'h800_0000, key_code};
          push_n   = 2'd1;
        end else begin
          dropped_d = 1'b1;
        end
      end
    end

    // Pointer/count update. A flush rebuilds the FIFO as exactly the clear
    // token; a same-cycle pop has already captured its entry from mem_q.
    if (flush) begin
      wr0_en   = 1'b1;
      wr0_addr = '0;
      wr0_data = CLEAR_TOK;
      wr1_en   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = PW'(1);
      count_d  = CW'(1);
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      count_d  = count_q + CW'(push_n) - CW'(pop);
    end

    disp_d = pending_d ? acc_d : calc_answer;
    busy_d = (count_d != '0) || (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      pending_q   <= 1'b0;
      entry_err_q <= 1'b0;
      dropped_q   <= 1'b0;
      strobe_q    <= 1'b0;
      token_q     <= '0;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
      disp_q      <= '0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pending_q   <= pending_d;
      entry_err_q <= entry_err_d;
      dropped_q   <= dropped_d;
      strobe_q    <= strobe_d;
      token_q     <= token_d;
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
      disp_q      <= disp_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Token storage; contents are meaningless outside [rd_ptr, wr_ptr).
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      mem_q[wr0_addr] <= wr0_data;
    end
    if (wr1_en) begin
      mem_q[wr1_addr] <= wr1_data;
    end
  end

  assign calc_strobe  = strobe_q;
  assign calc_token   = token_q;
  assign disp_value   = disp_q;
  assign busy         = busy_q;
  assign dropped      = dropped_q;
  assign entry_err    = entry_err_q;
  assign calc_timeout = timeout_q;

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_C);
  a_strobe_state : assert property (@(posedge clk) disable iff (!rst_n)
    strobe_q == (state_q == S_STROBE));

endmodule

// File: tb/tb_calc_token_sequencer.sv
module tb_calc_token_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        calc_ready;
  logic [31:0] calc_answer = 32'd0;
  logic        calc_strobe;
  logic [31:0] calc_token;
  logic [31:0] disp_value;
  logic        busy;
  logic        dropped;
  logic        entry_err;
  logic        calc_timeout;

  logic        auto_core = 1'b0;
  logic        manual_ready = 1'b0;
  int          core_hold = 0;

  int          checks = 0;
  int          failures = 0;

  logic [31:0] got_q[$];
  int          strobe_viol = 0;
  int          ready_viol = 0;
  int          tok_viol = 0;
  logic        prev_strobe = 1'b0;
  logic [31:0] prev_tok = 32'd0;

  assign calc_ready = auto_core ? (core_hold == 0) : manual_ready;

  always #5 clk = ~clk;

  calc_token_sequencer #(
    .FIFO_DEPTH(8),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .key_code(key_code),
    .calc_ready(calc_ready),
    .calc_answer(calc_answer),
    .calc_strobe(calc_strobe),
    .calc_token(calc_token),
    .disp_value(disp_value),
    .busy(busy),
    .dropped(dropped),
    .entry_err(entry_err),
    .calc_timeout(calc_timeout)
  );

  // Core model and token recorder. In auto mode the core drops ready for
  // three cycles after each strobe.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strobe = 1'b0;
      prev_tok    = 32'd0;
      core_hold   = 0;
    end else begin
      if (calc_strobe) begin
        got_q.push_back(calc_token);
        if (prev_strobe) strobe_viol++;
        if (core_hold != 0) ready_viol++;
        if (auto_core) core_hold = 3;
      end else if (core_hold != 0) begin
        core_hold--;
      end
      if (calc_token !== prev_tok && !calc_strobe) tok_viol++;
      prev_strobe = calc_strobe;
      prev_tok    = calc_token;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_tokens(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    calc_answer = 32'h0000_1234;
    repeat (3) @(negedge clk);
    checks++;
    if (calc_strobe !== 1'b0 || calc_timeout !== 1'b0 || dropped !== 1'b0 || entry_err !== 1'b0)
      begin failures++; $display("FAIL reset_flags: got strobe=%b tmo=%b drop=%b err=%b expected 0 0 0 0", calc_strobe, calc_timeout, dropped, entry_err); end
    checks++;
    if (calc_token !== 32'd0) begin failures++; $display("FAIL reset_token: got %h expected 00000000", calc_token); end
    checks++;
    if (disp_value !== 32'd0) begin failures++; $display("FAIL reset_disp: got %h expected 00000000", disp_value); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (disp_value !== 32'h0000_1234) begin failures++; $display("FAIL post_reset_disp: got %h expected 00001234", disp_value); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int base;
    int sv0, rv0, tv0;
    logic [31:0] exp [4];
    exp  = '{32'd18, 32'h8000_000A, 32'd9, 32'h8000_000E};
    base = got_q.size();
    sv0 = strobe_viol; rv0 = ready_viol; tv0 = tok_viol;
    auto_core = 1'b1;
    press(4'd1); press(4'd8); press(4'hA); press(4'd9); press(4'hE);
    wait_tokens(base + 4, 300);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== base + 4) begin failures++; $display("FAIL basic_count: got %0d expected %0d", got_q.size() - base, 4); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < got_q.size()) begin
        checks++;
        if (got_q[base + i] !== exp[i]) begin failures++; $display("FAIL basic_tok[%0d]: got %h expected %h", i, got_q[base + i], exp[i]); end
      end
    end
    checks++;
    if (strobe_viol !== sv0) begin failures++; $display("FAIL basic_strobe_width: got %0d long strobes expected 0", strobe_viol - sv0); end
    checks++;
    if (ready_viol !== rv0) begin failures++; $display("FAIL basic_ready_wait: got %0d early strobes expected 0", ready_viol - rv0); end
    checks++;
    if (tok_viol !== tv0) begin failures++; $display("FAIL basic_token_stable: got %0d changes expected 0", tok_viol - tv0); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_overflow();
    int base;
    int digs [10];
    digs = '{2, 1, 4, 7, 4, 8, 3, 6, 4, 7};
    wait_idle(200);
    base = got_q.size();
    foreach (digs[i]) press(4'(digs[i]));
    checks++;
    if (disp_value !== 32'd2147483647) begin failures++; $display("FAIL max_operand_disp: got %0d expected 2147483647", disp_value); end
    checks++;
    if (entry_err !== 1'b0) begin failures++; $display("FAIL max_operand_err: got %b expected 0", entry_err); end
    press(4'd0);
    checks++;
    if (entry_err !== 1'b1) begin failures++; $display("FAIL overflow_err: got %b expected 1", entry_err); end
    checks++;
    if (disp_value !== 32'd2147483647) begin failures++; $display("FAIL overflow_disp: got %0d expected 2147483647", disp_value); end
    press(4'hF);
    checks++;
    if (entry_err !== 1'b0) begin failures++; $display("FAIL clear_err: got %b expected 0", entry_err); end
    checks++;
    if (disp_value !== 32'h0000_1234) begin failures++; $display("FAIL clear_disp: got %h expected 00001234", disp_value); end
    wait_tokens(base + 1, 100);
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() !== base + 1) begin failures++; $display("FAIL clear_tok_count: got %0d expected 1", got_q.size() - base); end
    else begin
      checks++;
      if (got_q[base] !== 32'h8000_000F) begin failures++; $display("FAIL clear_tok: got %h expected 8000000f", got_q[base]); end
    end
  endtask

  task automatic test_full_drop();
    int base;
    logic [31:0] e;
    wait_idle(200);
    auto_core = 1'b0;
    manual_ready = 1'b0;
    base = got_q.size();
    for (int i = 0; i < 4; i++) begin
      press(4'd5);
      press(4'hA);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL full_busy: got %b expected 1", busy); end
    press(4'd3);
    press(4'hB);
    checks++;
    if (dropped !== 1'b1) begin failures++; $display("FAIL drop_pulse: got %b expected 1", dropped); end
    @(negedge clk);
    checks++;
    if (dropped !== 1'b0) begin failures++; $display("FAIL drop_width: got %b expected 0", dropped); end
    checks++;
    if (disp_value !== 32'd3) begin failures++; $display("FAIL drop_acc_kept: got %0d expected 3", disp_value); end
    checks++;
    if (got_q.size() !== base) begin failures++; $display("FAIL full_no_dispatch: got %0d tokens expected 0", got_q.size() - base); end
    auto_core = 1'b1;
    wait_tokens(base + 8, 400);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== base + 8) begin failures++; $display("FAIL drain_count: got %0d expected 8", got_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      e = (i % 2 == 0) ? 32'd5 : 32'h8000_000A;
      if (base + i < got_q.size()) begin
        checks++;
        if (got_q[base + i] !== e) begin failures++; $display("FAIL drain_tok[%0d]: got %h expected %h", i, got_q[base + i], e); end
      end
    end
    press(4'hF);
    wait_tokens(base + 9, 100);
    wait_idle(200);
  endtask

  task automatic test_clear_mid();
    int base;
    int tv0;
    wait_idle(200);
    auto_core = 1'b0;
    manual_ready = 1'b0;
    base = got_q.size();
    tv0 = tok_viol;
    press(4'd7); press(4'hA); press(4'hC);
    manual_ready = 1'b1;
    for (int i = 0; i < 10 && !calc_strobe; i++) @(negedge clk);
    manual_ready = 1'b0;
    checks++;
    if (calc_strobe !== 1'b1) begin failures++; $display("FAIL cm_first_strobe: got %b expected 1", calc_strobe); end
    repeat (2) @(negedge clk);
    press(4'hF);
    checks++;
    if (calc_token !== 32'd7) begin failures++; $display("FAIL cm_token_held: got %h expected 00000007", calc_token); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL cm_busy: got %b expected 1", busy); end
    auto_core = 1'b1;
    wait_tokens(base + 2, 100);
    repeat (40) @(negedge clk);
    checks++;
    if (got_q.size() !== base + 2) begin failures++; $display("FAIL cm_count: got %0d expected 2", got_q.size() - base); end
    else begin
      checks++;
      if (got_q[base] !== 32'd7) begin failures++; $display("FAIL cm_tok0: got %h expected 00000007", got_q[base]); end
      checks++;
      if (got_q[base + 1] !== 32'h8000_000F) begin failures++; $display("FAIL cm_tok1: got %h expected 8000000f", got_q[base + 1]); end
    end
    checks++;
    if (tok_viol !== tv0) begin failures++; $display("FAIL cm_token_stable: got %0d changes expected 0", tok_viol - tv0); end
  endtask

  task automatic test_timeout();
    int base;
    int k;
    wait_idle(200);
    auto_core = 1'b0;
    manual_ready = 1'b0;
    base = got_q.size();
    press(4'd4); press(4'hD);
    manual_ready = 1'b1;
    for (int i = 0; i < 10 && !calc_strobe; i++) @(negedge clk);
    manual_ready = 1'b0;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (calc_timeout) k = i;
    end
    checks++;
    if (k !== 18) begin failures++; $display("FAIL timeout_latency: got %0d cycles after strobe expected 18", k); end
    @(negedge clk);
    checks++;
    if (calc_timeout !== 1'b0) begin failures++; $display("FAIL timeout_width: got %b expected 0", calc_timeout); end
    checks++;
    if (got_q.size() !== base + 1) begin failures++; $display("FAIL timeout_no_strobe: got %0d tokens expected 1", got_q.size() - base); end
    manual_ready = 1'b1;
    wait_tokens(base + 2, 30);
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() !== base + 2) begin failures++; $display("FAIL timeout_next_count: got %0d expected 2", got_q.size() - base); end
    else begin
      checks++;
      if (got_q[base + 1] !== 32'h8000_000D) begin failures++; $display("FAIL timeout_next_tok: got %h expected 8000000d", got_q[base + 1]); end
    end
    auto_core = 1'b1;
  endtask

  task automatic test_reset_mid();
    int s1;
    wait_idle(200);
    auto_core = 1'b0;
    manual_ready = 1'b0;
    press(4'd1); press(4'hA); press(4'd2); press(4'hB); press(4'd3); press(4'hC);
    manual_ready = 1'b1;
    for (int i = 0; i < 10 && !calc_strobe; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (calc_strobe !== 1'b1) begin failures++; $display("FAIL rm_strobe_seen: got %b expected 1", calc_strobe); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (calc_strobe !== 1'b0) begin failures++; $display("FAIL rm_strobe: got %b expected 0", calc_strobe); end
    checks++;
    if (calc_token !== 32'd0) begin failures++; $display("FAIL rm_token: got %h expected 00000000", calc_token); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b expected 0", busy); end
    s1 = got_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (got_q.size() !== s1) begin failures++; $display("FAIL rm_flushed: got %0d tokens expected 0", got_q.size() - s1); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rm_idle: got %b expected 0", busy); end
    press(4'hE);
    wait_tokens(s1 + 1, 30);
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() !== s1 + 1) begin failures++; $display("FAIL rm_new_count: got %0d expected 1", got_q.size() - s1); end
    else begin
      checks++;
      if (got_q[s1] !== 32'h8000_000E) begin failures++; $display("FAIL rm_new_tok: got %h expected 8000000e", got_q[s1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_drop();
    test_clear_mid();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_token_sequencer.md
Name: calc_token_sequencer

Overview:
Sits between the keypad decoder and the four-function calculator core. It converts raw key events into calculator tokens: decimal digits are assembled into one 32-bit operand, and operator keys become 0x8000000A–0x8000000F tokens. Tokens are buffered in a small FIFO and dispatched to the core over its strobe/ready handshake. This replaces bench-style token injection with synthesizable sequencing and also selects the value shown on the display.

Parameters:
FIFO_DEPTH, 8, token FIFO entries; power of 2, minimum 2
TIMEOUT, 1024, max cycles in WAIT for calc_ready; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  one-cycle pulse, key_code valid
key_code  input  4  0-9 digit, A + , B - , C * , D / , E = , F clear
calc_ready  input  1  core ready for a token
calc_answer  input  32  core result
calc_strobe  output  1  one-cycle token strobe to core
calc_token  output  32  token to core; stable from pop until next pop
disp_value  output  32  value for the seven-segment controller
busy  output  1  FIFO non-empty or dispatcher not in IDLE
dropped  output  1  one-cycle pulse: key rejected because the FIFO lacked room
entry_err  output  1  sticky: operand overflow
calc_timeout  output  1  one-cycle pulse: ready wait expired

Behaviour:
- Reset (async, rst_n low): all outputs 0; acc=0; pending=0; FIFO empty; FSM=IDLE. Reset mid-dispatch aborts the dispatch and discards queued tokens.
- Digit key d (0-9): next = acc*10+d, computed at 35 bits.
  - If next ≤ 0x7FFFFFFF: acc<=next, pending<=1.
  - Otherwise: acc is unchanged and entry_err<=1.
  - No FIFO activity.
- Operator key A-E:
  - If pending=1: needs 2 free slots. Enqueue {1'b0,acc[30:0]}, then {28'h8000000,key_code}, in that order, in the same cycle. Then acc<=0, pending<=0.
  - If pending=0: needs 1 free slot. Enqueue the operator token only.
  - If there is insufficient room: nothing is enqueued, acc and pending are unchanged, and dropped pulses.
- Clear key F: FIFO flushed, acc<=0, pending<=0, entry_err<=0, and 0x8000000F enqueued, all in one cycle.
  - Clear is always accepted.
  - A token already popped into calc_token finishes its dispatch.
- Simultaneous push and pop in one cycle: both take effect and the count stays correct.
- Clear plus pop in one cycle: the pop completes, and the FIFO then holds exactly the clear token.
- Dispatcher FSM:
  - IDLE: if FIFO non-empty and calc_ready=1, pop into calc_token and go to STROBE.
  - STROBE: calc_strobe=1 for exactly one cycle, then go to HOLD.
  - HOLD: strobe 0 for one cycle, so the core can drop ready; then go to WAIT.
  - WAIT: when calc_ready=1, go to IDLE. If TIMEOUT≠0 and TIMEOUT cycles elapse in WAIT, pulse calc_timeout and go to IDLE.
- Minimum token spacing is 4 cycles (pop, strobe, hold, wait≥1). Tokens are never reordered or duplicated.
- disp_value = pending ? acc : calc_answer. It is a registered select, updating the cycle after any change.
- busy = (count≠0) | (state≠IDLE).
- key_valid is assumed to be a single-cycle pulse; holding it high is treated as repeated keys.

Test Plan:
1. Reset, then keys 1,8,A,9,E with ready high whenever idle → tokens 18, 0x8000000A, 9, 0x8000000E in order. Each strobe lasts 1 cycle; calc_token is stable through WAIT; no strobe occurs before ready returns.
2. Keys 2,1,4,7,4,8,3,6,4,7 then 0 → acc=2147483647 and entry_err=1 after the last key; disp_value=2147483647. Key F → entry_err=0, disp_value=calc_answer.
3. Hold calc_ready low with FIFO_DEPTH=8. Enqueue 4× (digit 5, key A) → count 8, busy=1. Key 3 then key B → dropped pulses, acc=3 retained. Release ready → the 8 tokens drain in order.
4. Queue 3 tokens, then key F while the first is in WAIT → the first dispatch completes; the next strobed token is 0x8000000F; no other tokens follow.
5. TIMEOUT=16: after the strobe, hold calc_ready low for 20 cycles → calc_timeout pulses 16 cycles after entering WAIT; FSM returns to IDLE and the next token dispatches once ready rises.
6. Assert rst_n=0 during STROBE with 5 tokens queued → calc_strobe=0, calc_token=0, busy=0 immediately (async); after release no token is strobed until a new key arrives.
